nebula_pqc_key_streamer: RTL and testbench
==========================================

// Module: nebula_pqc_key_streamer
// PURPOSE
//  Consumer end of the NEBULA PQC keygen interface. Captures the wide public/secret key
//  buses on the rising edge of the keygen done flag into shadow registers, then streams
//  them out LS-word first over a WORD_W valid/ready stream to the ESP32 host bridge.
//  Frame = PK words, then optionally SK words; m_last marks final word of frame.
// PARAMETERS
//  WORD_W  32    stream word width; PK_W and SK_W must be integer multiples
//  PK_W    512   public key bus width (PK_WORDS = PK_W/WORD_W = 16)
//  SK_W    1024  secret key bus width (SK_WORDS = SK_W/WORD_W = 32)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       reset, asynchronous, active-low
//  key_done     in   1       keygen done level; rising edge = new key pair valid
//  public_key   in   PK_W    keygen public key, sampled only on capture
//  secret_key   in   SK_W    keygen secret key, sampled only on capture
//  sk_enable    in   1       sampled on capture; 1 = append SK words to frame
//  flush        in   1       synchronous abort of current frame
//  clr_overrun  in   1       clears overrun flag
//  m_data       out  WORD_W  stream data
//  m_valid      out  1       stream valid
//  m_ready      in   1       stream ready from host bridge
//  m_last       out  1       final word of frame
//  m_sel        out  1       0 = word from PK, 1 = word from SK
//  busy         out  1       frame in progress (state != IDLE)
//  overrun      out  1       sticky: key_done edge seen while busy
// BEHAVIOUR
//  - Reset: state IDLE; m_data=0, m_valid=0, m_last=0, m_sel=0, busy=0, overrun=0,
//    shadows=0, word counter=0, key_done_q=0. Reset mid-frame drops frame, no partial resume.
//  - Edge detect: key_done_q <= key_done each cycle; rise = key_done & ~key_done_q.
//  - FSM: IDLE -> PK on rise (load pk/sk shadows, latch sk_enable, cnt=0).
//    PK -> SK on handshake of word PK_WORDS-1 when sk_en_latched; else -> IDLE.
//    SK -> IDLE on handshake of word SK_WORDS-1.
//  - Latency: rise sampled at edge N -> m_valid=1 with PK word 0 after edge N.
//  - Handshake: transfer when m_valid & m_ready. While m_valid & !m_ready, m_data/m_last/
//    m_sel held stable. Next word presented the cycle after a transfer: full throughput,
//    one word/cycle with m_ready held high; no bubble at PK->SK boundary.
//  - Word k of PK = public_key[k*WORD_W +: WORD_W]; same indexing for SK.
//  - m_last=1 only on PK word 15 (sk disabled) or SK word 31; m_sel=1 for all SK words.
//  - Counter clog2(max(PK_WORDS,SK_WORDS)) bits; reset to 0 at every state change.
//  - Return to IDLE: m_valid=0 the cycle after the final transfer. A rise in that same
//    cycle is an overrun, not a new frame (busy still 1).
//  - rise while busy: frame continues unchanged, overrun<=1; new key ignored.
//    key_done held high after frame: no retrigger (edge only).
//  - clr_overrun: overrun<=0 next cycle; simultaneous set and clear -> set wins.
//  - flush: state IDLE, m_valid/m_last/m_sel=0 next cycle, regardless of m_ready;
//    flush beats rise in same cycle (rise discarded, no overrun).
//  - Inputs public_key/secret_key/sk_enable ignored outside capture cycle.
// CONFIGURATION
//  NEBULA_KEYSTREAM_ZEROIZE_EN defined: SK shadow cleared to 0 in the cycle after SK word 31
//    transfers, on flush, and on capture when sk_enable=0; m_data driven 0 while m_valid=0.
//  Not defined: SK shadow retains last key until next capture; m_data holds last word
//    while m_valid=0.
// TESTING
//  1 PK word k = 32'hA000_0000+k, SK word k = 32'hB000_0000+k, sk_enable=1, m_ready=1,
//    pulse key_done -> 48 words back-to-back from cycle after edge; m_last on word 47 only.
//  2 sk_enable=0, same keys -> 16 words A000_0000..A000_000F, m_last on word 15, m_sel=0.
//  3 m_ready toggled 1-0-1 per cycle -> data/last/sel stable during stalls; words exact.
//  4 second key_done edge at word 5 -> overrun=1, frame unchanged;
//    clr_overrun -> overrun=0 next cycle.
//  5 flush at SK word 3 -> m_valid=0 next cycle, busy=0; next edge restarts at PK word 0.
//    Zeroize build: SK shadow reads 0.
//  6 reset_n low at PK word 10 -> all outputs 0 asynchronously; key_done held high after
//    release -> rise regenerated (key_done_q reset 0), full frame restarts.

Source files
------------

// File: rtl/nebula_pqc_key_streamer.sv
// Captures keygen public/secret key buses on the key_done rising edge and streams them LS-word first.
// Optional build macro: NEBULA_KEYSTREAM_ZEROIZE_EN (clears SK shadow after use, zeroes idle m_data).
module nebula_pqc_key_streamer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PK_W   = 512,
    parameter int unsigned SK_W   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_done,
    input  logic [PK_W-1:0]   public_key,
    input  logic [SK_W-1:0]   secret_key,
    input  logic              sk_enable,
    input  logic              flush,
    input  logic              clr_overrun,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              m_sel,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned PK_WORDS  = PK_W / WORD_W;
    localparam int unsigned SK_WORDS  = SK_W / WORD_W;
    localparam int unsigned MAX_WORDS = (PK_WORDS > SK_WORDS) ? PK_WORDS : SK_WORDS;
    localparam int unsigned CW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned PK_IW     = (PK_WORDS > 1) ? $clog2(PK_WORDS) : 1;
    localparam int unsigned SK_IW     = (SK_WORDS > 1) ? $clog2(SK_WORDS) : 1;
    localparam logic [CW-1:0] PK_LAST = CW'(PK_WORDS - 1);
    localparam logic [CW-1:0] SK_LAST = CW'(SK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PK, S_SK} state_t;

    state_t            state, state_d;
    logic              key_done_q;
    logic              sk_en_l;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [WORD_W-1:0] pk_sh [PK_WORDS];
    logic [WORD_W-1:0] sk_sh [SK_WORDS];
    logic              rise;
    logic              xfer;
    logic              capture;

    assign rise    = key_done & ~key_done_q;
    assign xfer    = m_valid & m_ready;
    assign capture = (state == S_IDLE) & rise & ~flush;
    assign cnt_n   = cnt + CW'(1);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (rise) state_d = S_PK;
                S_PK:   if (xfer && cnt == PK_LAST) state_d = sk_en_l ? S_SK : S_IDLE;
                S_SK:   if (xfer && cnt == SK_LAST) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The next word is registered on each handshake so the stream runs at one word per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_done_q <= 1'b0;
            overrun    <= 1'b0;
            sk_en_l    <= 1'b0;
            cnt        <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_sel      <= 1'b0;
            pk_sh      <= '{default: '0};
            sk_sh      <= '{default: '0};
        end else begin
            key_done_q <= key_done;
            if (rise && busy && !flush) overrun <= 1'b1;
            else if (clr_overrun)       overrun <= 1'b0;

            if (flush) begin
                cnt     <= '0;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                m_sel   <= 1'b0;
`ifdef NEBULA_KEYSTREAM_ZEROIZE_EN
                sk_sh   <= '{default: '0};
                m_data  <= '0;
`endif
            end else if (capture) begin
                for (int unsigned i = 0; i < PK_WORDS; i++)
                    pk_sh[i] <= public_key[i*WORD_W +: WORD_W];
                for (int unsigned i = 0; i < SK_WORDS; i++)
`ifdef NEBULA_KEYSTREAM_ZEROIZE_EN
                    sk_sh[i] <= sk_enable ? secret_key[i*WORD_W +: WORD_W] : '0;
`else
                    sk_sh[i] <= secret_key[i*WORD_W +: WORD_W];
`endif
                sk_en_l <= sk_enable;
                cnt     <= '0;
                m_data  <= public_key[WORD_W-1:0];
                m_valid <= 1'b1;
                m_sel   <= 1'b0;
                m_last  <= (PK_WORDS == 1) && !sk_enable;
            end else if (xfer) begin
                if (state == S_PK) begin
                    if (cnt == PK_LAST) begin
                        cnt <= '0;
                        if (sk_en_l) begin
                            m_data <= sk_sh[0];
                            m_sel  <= 1'b1;
                            m_last <= (SK_WORDS == 1);
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
`ifdef NEBULA_KEYSTREAM_ZEROIZE_EN
                            m_data  <= '0;
`endif
                        end
                    end else begin
                        cnt    <= cnt_n;
                        m_data <= pk_sh[cnt_n[PK_IW-1:0]];
                        m_last <= (cnt_n == PK_LAST) && !sk_en_l;
                    end
                end else begin
                    if (cnt == SK_LAST) begin
                        cnt     <= '0;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        m_sel   <= 1'b0;
`ifdef NEBULA_KEYSTREAM_ZEROIZE_EN
                        sk_sh   <= '{default: '0};
                        m_data  <= '0;
`endif
                    end else begin
                        cnt    <= cnt_n;
                        m_data <= sk_sh[cnt_n[SK_IW-1:0]];
                        m_last <= (cnt_n == SK_LAST);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nebula_pqc_key_streamer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_nebula_pqc_key_streamer;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned PK_W     = 512;
    localparam int unsigned SK_W     = 1024;
    localparam int unsigned PK_WORDS = PK_W / WORD_W;
    localparam int unsigned SK_WORDS = SK_W / WORD_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              key_done;
    logic [PK_W-1:0]   public_key;
    logic [SK_W-1:0]   secret_key;
    logic              sk_enable;
    logic              flush;
    logic              clr_overrun;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              m_sel;
    logic              busy;
    logic              overrun;

    nebula_pqc_key_streamer #(
        .WORD_W(WORD_W),
        .PK_W  (PK_W),
        .SK_W  (SK_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_done   (key_done),
        .public_key (public_key),
        .secret_key (secret_key),
        .sk_enable  (sk_enable),
        .flush      (flush),
        .clr_overrun(clr_overrun),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_sel      (m_sel),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic              l;
        logic              s;
    } word_t;

    word_t             exp_q[$];
    logic              mdl_kd_q;
    logic              mdl_ovr;
    logic [WORD_W-1:0] mdl_last_data;
    int unsigned       n_checks;
    int unsigned       n_errors;
    int unsigned       dut_xfers;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        exp_q.delete();
        mdl_kd_q      = 1'b0;
        mdl_ovr       = 1'b0;
        mdl_last_data = '0;
    endtask

    // A frame is simply the ordered list of words the host must receive.
    task automatic mdl_capture();
        word_t w;
        for (int unsigned k = 0; k < PK_WORDS; k++) begin
            w.d = public_key[k*WORD_W +: WORD_W];
            w.l = (k == PK_WORDS - 1) && !sk_enable;
            w.s = 1'b0;
            exp_q.push_back(w);
        end
        if (sk_enable) begin
            for (int unsigned k = 0; k < SK_WORDS; k++) begin
                w.d = secret_key[k*WORD_W +: WORD_W];
                w.l = (k == SK_WORDS - 1);
                w.s = 1'b1;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic mdl_step(input logic kd, input logic rdy, input logic fl, input logic clr);
        logic rise;
        logic was_busy;
        rise     = kd && !mdl_kd_q;
        mdl_kd_q = kd;
        was_busy = (exp_q.size() != 0);
        if (rise && was_busy && !fl) mdl_ovr = 1'b1;
        else if (clr)                mdl_ovr = 1'b0;
        if (fl)                      exp_q.delete();
        else if (rise && !was_busy)  mdl_capture();
        else if (was_busy && rdy)    void'(exp_q.pop_front());
    endtask

    task automatic check_outputs();
        logic [WORD_W-1:0] idle_data;
        check_eq("valid",   m_valid, exp_q.size() != 0);
        check_eq("busy",    busy,    exp_q.size() != 0);
        check_eq("overrun", overrun, mdl_ovr);
        if (exp_q.size() != 0) begin
            mdl_last_data = exp_q[0].d;
            check_eq("data", m_data, exp_q[0].d);
            check_eq("last", m_last, exp_q[0].l);
            check_eq("sel",  m_sel,  exp_q[0].s);
        end else begin
`ifdef NEBULA_KEYSTREAM_ZEROIZE_EN
            idle_data = '0;
`else
            idle_data = mdl_last_data;
`endif
            check_eq("idle_data", m_data, idle_data);
            check_eq("idle_last", m_last, 1'b0);
            check_eq("idle_sel",  m_sel,  1'b0);
        end
    endtask

    task automatic scramble();
        for (int unsigned i = 0; i < PK_W / 32; i++) public_key[i*32 +: 32] = $urandom();
        for (int unsigned i = 0; i < SK_W / 32; i++) secret_key[i*32 +: 32] = $urandom();
        sk_enable = 1'($urandom_range(0, 1));
    endtask

    task automatic set_pattern(input logic ske);
        for (int unsigned k = 0; k < PK_WORDS; k++) public_key[k*WORD_W +: WORD_W] = 32'hA000_0000 + k;
        for (int unsigned k = 0; k < SK_WORDS; k++) secret_key[k*WORD_W +: WORD_W] = 32'hB000_0000 + k;
        sk_enable = ske;
    endtask

    // Called at a falling edge; applies inputs for the next rising edge, then checks after it.
    task automatic step(input logic kd, input logic rdy, input logic fl, input logic clr);
        if (!(kd && !mdl_kd_q)) scramble();
        key_done    = kd;
        m_ready     = rdy;
        flush       = fl;
        clr_overrun = clr;
        if (m_valid && m_ready) dut_xfers++;
        mdl_step(kd, rdy, fl, clr);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic kd, rdy, fl, clr;
        n_checks = 0; n_errors = 0; dut_xfers = 0;
        reset_n = 1'b0; key_done = 1'b0; flush = 1'b0; clr_overrun = 1'b0; m_ready = 1'b0;
        public_key = '0; secret_key = '0; sk_enable = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Full PK+SK frame, back-to-back, key_done left high afterwards
        set_pattern(1'b1);
        dut_xfers = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (52) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t1_words", dut_xfers, 48);

        // PK-only frame
        step(1'b0, 1'b1, 1'b0, 1'b0);
        set_pattern(1'b0);
        dut_xfers = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t2_words", dut_xfers, 16);

        // Alternating ready
        set_pattern(1'b1);
        dut_xfers = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, (i % 2) == 0, 1'b0, 1'b0);
        check_eq("t3_words", dut_xfers, 48);

        // Second edge mid-frame (with simultaneous clear), then clear
        set_pattern(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t4_ovr_set", overrun, 1'b1);
        repeat (45) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_ovr_clr", overrun, 1'b0);

        // Flush at SK word 3 with ready low, flush beating a rise, then restart
        set_pattern(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (19) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t5_at_sk3", m_data, 32'hB000_0003);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        set_pattern(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t5_restart", m_data, 32'hA000_0000);
        repeat (50) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, key_done held high across release
        set_pattern(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 mdl_reset();
        check_outputs();
        check_eq("t6_rst_data", m_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        set_pattern(1'b1);
        dut_xfers = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_words", dut_xfers, 48);

        // Random traffic
        kd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) kd = ~kd;
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 49) == 0);
            step(kd, rdy, fl, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
